// File: rtl/bus_slave_port.sv
// Slave endpoint of the serial bit-per-cycle bus: deserialises address/data write frames
// into a small local register memory and exposes a registered read port.
module bus_slave_port #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_AW     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_s_address,
  input  logic                  i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [MEM_AW-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_wr_done,
  output logic                  o_err
);

  localparam int unsigned MemDepth = 2 ** MEM_AW;
  localparam int unsigned CntMax   = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CntW     = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_WIDTH - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StWrite
  } state_e;

  state_e                r_state, w_state_next;
  logic [CntW-1:0]       r_cnt, w_cnt_next;
  // Only the index bits are kept; upper address bits shift out and are dropped.
  logic [MEM_AW-1:0]     r_addr, w_addr_next;
  logic [DATA_WIDTH-1:0] r_data, w_data_next;
  logic                  w_abort;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_mem [MemDepth];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    w_data_next  = r_data;
    w_abort      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_s_valid) begin
          w_state_next = StAddr;
          w_cnt_next   = CntW'(1);
          w_addr_next  = MEM_AW'(i_s_address);
          w_data_next  = '0;
        end
      end
      StAddr: begin
        if (i_s_valid) begin
          w_addr_next = (r_addr << 1) | MEM_AW'(i_s_address);
          if (r_cnt == AddrLast) begin
            w_state_next = StData;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end else begin
          w_abort = 1'b1;
        end
      end
      StData: begin
        if (i_s_valid) begin
          w_data_next = (r_data << 1) | DATA_WIDTH'(i_s_data);
          if (r_cnt == DataLast) begin
            w_state_next = StWrite;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end else begin
          w_abort = 1'b1;
        end
      end
      StWrite: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    if (w_abort) begin
      w_state_next = StIdle;
      w_cnt_next   = '0;
      w_addr_next  = '0;
      w_data_next  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_addr    <= w_addr_next;
      r_data    <= w_data_next;
      r_err     <= w_abort;
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  // Memory is deliberately outside reset; a reset landing on WRITE discards the frame.
  always_ff @(posedge i_clk) begin
    if (!i_reset && (r_state == StWrite)) begin
      r_mem[r_addr] <= r_data;
    end
  end

  assign o_s_ready = (r_state == StIdle);
  assign o_wr_done = (r_state == StWrite);
  assign o_err     = r_err;
  assign o_rd_data = r_rd_data;

endmodule

// File: tb/tb_bus_slave_port.sv
// Randomised self-checking bench for bus_slave_port: frames are generated from address/data
// words and checked against a frame-timing model plus an array model of the memory.
module tb_bus_slave_port;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int N  = AW + DW;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_address = 1'b0;
  logic       s_data = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       wr_done;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_mem [16];
  bit         m_ok  [16];
  bit         rd_known = 1'b0;
  logic [7:0] rd_exp = '0;
  logic       exp_err = 1'b0;

  bus_slave_port #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_AW    (4)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_s_address(s_address),
    .i_s_data   (s_data),
    .i_s_valid  (s_valid),
    .o_s_ready  (s_ready),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_wr_done  (wr_done),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: check outputs of the current cycle, then drive inputs for its closing edge.
  task automatic cyc(input logic v, input logic a, input logic d, input logic rst,
                     input logic [3:0] rd, input logic exp_rdy, input logic exp_wd,
                     input logic we, input logic [3:0] widx, input logic [7:0] wdat,
                     input logic abort);
    @(negedge clk);
    check_eq("s_ready", 32'(s_ready), 32'(exp_rdy));
    check_eq("wr_done", 32'(wr_done), 32'(exp_wd));
    check_eq("err", 32'(err), 32'(exp_err));
    if (rd_known) check_eq("rd_data", 32'(rd_data), 32'(rd_exp));
    s_valid   = v;
    s_address = a;
    s_data    = d;
    reset     = rst;
    rd_addr   = rd;
    // Read sees memory before this edge's write.
    if (rst) begin
      rd_known = 1'b1;
      rd_exp   = '0;
    end else begin
      rd_known = m_ok[rd];
      rd_exp   = m_mem[rd];
    end
    if (we && !rst) begin
      m_mem[widx] = wdat;
      m_ok[widx]  = 1'b1;
    end
    exp_err = abort && !rst;
  endtask

  task automatic idle(input logic [3:0] rd);
    cyc(1'b0, 1'($urandom), 1'($urandom), 1'b0, rd, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0, 1'b0);
  endtask

  // Frame cycles 0..N; abort_at drops s_valid, rst_at asserts reset (-1 = never).
  task automatic frame(input logic [11:0] addr, input logic [7:0] data, input int abort_at,
                       input int rst_at);
    for (int c = 0; c <= N; c++) begin
      logic a;
      logic d;
      a = (c < AW) ? addr[AW-1-c] : 1'($urandom);
      d = (c >= AW && c < N) ? data[N-1-c] : 1'($urandom);
      if (c == rst_at) begin
        cyc(1'b0, a, d, 1'b1, 4'($urandom), c == 0, c == N, 1'b0, 4'h0, 8'h0, 1'b0);
        return;
      end
      if (c == abort_at) begin
        cyc(1'b0, a, d, 1'b0, 4'($urandom), c == 0, 1'b0, 1'b0, 4'h0, 8'h0, 1'b1);
        return;
      end
      cyc((c == N) ? 1'($urandom) : 1'b1, a, d, 1'b0, 4'($urandom), c == 0, c == N, c == N,
          addr[3:0], data, 1'b0);
    end
  endtask

  task automatic read_chk(input logic [3:0] idx, input logic [7:0] exp);
    idle(idx);
    idle(idx);
    check_eq("rd_direct", 32'(rd_data), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_ok[i]  = 1'b0;
      m_mem[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(s_ready), 32'd1);
    check_eq("rst_wr_done", 32'(wr_done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;

    frame(12'h005, 8'hA5, -1, -1);
    read_chk(4'd5, 8'hA5);

    frame(12'hFF3, 8'h3C, -1, -1);
    read_chk(4'd3, 8'h3C);
    read_chk(4'd5, 8'hA5);

    frame(12'h001, 8'h11, -1, -1);
    frame(12'h002, 8'h22, -1, -1);
    read_chk(4'd1, 8'h11);
    read_chk(4'd2, 8'h22);

    frame(12'h005, 8'h5A, 7, -1);
    idle(4'd5);
    read_chk(4'd5, 8'hA5);

    frame(12'h004, 8'h44, -1, -1);
    frame(12'h004, 8'h99, -1, 15);
    idle(4'd4);
    read_chk(4'd4, 8'h44);
    frame(12'h004, 8'h77, -1, -1);
    read_chk(4'd4, 8'h77);

    for (int k = 0; k < 40; k++) begin
      int kind;
      kind = int'($urandom_range(0, 7));
      if (kind == 6) begin
        frame(12'($urandom), 8'($urandom), int'($urandom_range(1, N - 1)), -1);
      end else if (kind == 7) begin
        frame(12'($urandom), 8'($urandom), -1, int'($urandom_range(1, N - 1)));
      end else begin
        frame(12'($urandom), 8'($urandom), -1, -1);
      end
      repeat ($urandom_range(0, 2)) idle(4'($urandom));
    end

    for (int i = 0; i < 16; i++) idle(4'(i));
    idle(4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
